// File: rtl/soc_pio_out_blink.sv
// soc_pio_out_blink: Avalon-MM output PIO with set/clear/toggle, per-bit blink and registered pins
module soc_pio_out_blink #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int PERIOD_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);
  logic [WIDTH-1:0] data_q, data_d, blink_q, blink_d, out_q, wd;
  logic [PERIOD_W-1:0] period_q, period_d, cnt_q, cnt_d, pd;
  logic phase_q, phase_d, wr, pwr, tc;
  logic unused_bits;
  assign unused_bits = ^writedata;
  assign wr = chipselect && !write_n;
  assign wd = writedata[WIDTH-1:0];
  assign pd = writedata[PERIOD_W-1:0];
  assign pwr = wr && address == 3'd5;
  assign tc = period_q != '0 && cnt_q == period_q - 1'b1;
  always_comb begin
    data_d = !wr ? data_q :
             address == 3'd0 ? wd :
             address == 3'd1 ? data_q | wd :
             address == 3'd2 ? data_q & ~wd :
             address == 3'd3 ? data_q ^ wd : data_q;
    blink_d = wr && address == 3'd4 ? wd : blink_q;
    period_d = pwr ? pd : period_q;
    // A PERIOD write restarts the blink and wins over a terminal count
    cnt_d = (pwr || period_q == '0 || tc) ? '0 : cnt_q + 1'b1;
    phase_d = pwr ? 1'b0 : tc ? ~phase_q : phase_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= RESET_VALUE;
      blink_q <= '0;
      period_q <= '0;
      cnt_q <= '0;
      phase_q <= 1'b0;
      out_q <= RESET_VALUE;
    end else begin
      data_q <= data_d;
      blink_q <= blink_d;
      period_q <= period_d;
      cnt_q <= cnt_d;
      phase_q <= phase_d;
      out_q <= data_q ^ (blink_q & {WIDTH{phase_q}});
    end
  end
  always_comb begin
    readdata = address <= 3'd3 ? 32'(data_q) :
               address == 3'd4 ? 32'(blink_q) :
               address == 3'd5 ? 32'(period_q) :
               address == 3'd6 ? 32'({cnt_q, phase_q}) : 32'(out_q);
  end
  assign out_port = out_q;
endmodule

// File: tb/tb_soc_pio_out_blink.sv
// tb_soc_pio_out_blink: vector table, hand-written blink/reset sequences and a randomized model check
module tb_soc_pio_out_blink;
  localparam logic [7:0] RV = 8'hA5;
  logic clk = 1'b0;
  logic reset = 1'b1, chipselect = 1'b0, write_n = 1'b1;
  logic [2:0] address = '0;
  logic [31:0] writedata = '0, readdata;
  logic [7:0] out_port;
  int checks = 0, passed = 0;

  soc_pio_out_blink #(.WIDTH(8), .RESET_VALUE(RV), .PERIOD_W(24)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata), .out_port(out_port)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model: blink state derived arithmetically from time since the last PERIOD write
  int t = 0, tw = 0, mp = 0;
  logic [7:0] md = RV, mb = '0, mo = RV;

  function automatic logic m_phase();
    return mp == 0 ? 1'b0 : 1'(((t - tw) / mp) % 2);
  endfunction

  function automatic int m_cnt();
    return mp == 0 ? 0 : (t - tw) % mp;
  endfunction

  function automatic logic [31:0] m_rd(input logic [2:0] a);
    if (a <= 3) return {24'h0, md};
    if (a == 4) return {24'h0, mb};
    if (a == 5) return 32'(mp);
    if (a == 6) return 32'((m_cnt() * 2) + int'(m_phase()));
    return {24'h0, mo};
  endfunction

  task automatic m_edge();
    logic [7:0] nxt, w8;
    nxt = md ^ (mb & {8{m_phase()}});
    w8 = writedata[7:0];
    t++;
    if (reset) begin
      md = RV; mb = '0; mp = 0; tw = t; mo = RV;
    end else begin
      mo = nxt;
      if (chipselect && !write_n)
        case (address)
          3'd0: md = w8;
          3'd1: md = md | w8;
          3'd2: md = md & ~w8;
          3'd3: md = md ^ w8;
          3'd4: mb = w8;
          3'd5: begin mp = int'(writedata[23:0]); tw = t; end
          default: ;
        endcase
    end
  endtask

  task automatic tick();
    @(posedge clk);
    m_edge();
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input string name, input logic [2:0] a, input logic [31:0] exp);
    address = a;
    #1;
    chk(name, readdata, exp);
  endtask

  typedef struct {
    logic rst; logic wr; logic [2:0] addr; logic [31:0] wd;
    logic [2:0] ra; logic [7:0] exp_out; logic [31:0] exp_rd;
  } vec_t;
  vec_t vt[9];

  initial begin
    vt[0] = '{1'b1, 1'b0, 3'd0, 32'h0,        3'd0, 8'hA5, 32'hA5};
    vt[1] = '{1'b0, 1'b0, 3'd0, 32'h0,        3'd5, 8'hA5, 32'h0};
    vt[2] = '{1'b0, 1'b1, 3'd0, 32'h0F,       3'd0, 8'hA5, 32'h0F};
    vt[3] = '{1'b0, 1'b1, 3'd1, 32'hF0,       3'd1, 8'h0F, 32'hFF};
    vt[4] = '{1'b0, 1'b1, 3'd2, 32'h03,       3'd2, 8'hFF, 32'hFC};
    vt[5] = '{1'b0, 1'b1, 3'd3, 32'hFFFF_FF81,3'd3, 8'hFC, 32'h7D};
    vt[6] = '{1'b0, 1'b0, 3'd0, 32'h0,        3'd7, 8'h7D, 32'h7D};
    vt[7] = '{1'b0, 1'b1, 3'd6, 32'hFFFF_FFFF,3'd6, 8'h7D, 32'h0};
    vt[8] = '{1'b0, 1'b1, 3'd7, 32'h0,        3'd1, 8'h7D, 32'h7D};
    for (int i = 0; i < 9; i++) begin
      reset = vt[i].rst; chipselect = vt[i].wr; write_n = !vt[i].wr;
      address = vt[i].addr; writedata = vt[i].wd;
      tick();
      reset = 1'b0; chipselect = 1'b0; write_n = 1'b1;
      chk($sformatf("vec%0d out", i), 32'(out_port), 32'(vt[i].exp_out));
      rd($sformatf("vec%0d rd", i), vt[i].ra, vt[i].exp_rd);
    end

    // Blink bit 0 with half-period 4
    wr(3'd0, 32'h0); wr(3'd4, 32'h1); wr(3'd5, 32'h4);
    rd("blink start status", 3'd6, 32'h0);
    for (int k = 1; k <= 15; k++) begin
      tick();
      chk($sformatf("blink out k%0d", k), 32'(out_port), (k >= 5 && k <= 8) || k >= 13 ? 32'h1 : 32'h0);
      rd($sformatf("blink status k%0d", k), 3'd6, 32'(((k % 4) << 1) | ((k / 4) % 2)));
    end
    wr(3'd5, 32'h2);
    rd("rewrite status", 3'd6, 32'h0);
    tick(); rd("rewrite +1", 3'd6, 32'h2);
    tick(); rd("rewrite +2", 3'd6, 32'h1);
    chk("rewrite out", 32'(out_port), 32'h0);
    wr(3'd5, 32'h0);
    rd("freeze status", 3'd6, 32'h0);
    tick(); tick();
    rd("frozen status", 3'd6, 32'h0);
    chk("frozen out", 32'(out_port), 32'h0);
    wr(3'd0, 32'h1); tick();
    chk("frozen data", 32'(out_port), 32'h1);
    wr(3'd4, 32'h0); wr(3'd0, 32'h3C); tick();
    chk("no blink out", 32'(out_port), 32'h3C);

    // Reset mid-blink with concurrent DATA write
    wr(3'd4, 32'hFF); wr(3'd5, 32'h1); tick(); tick();
    reset = 1'b1; chipselect = 1'b1; write_n = 1'b0; address = 3'd0; writedata = 32'hFF;
    tick();
    reset = 1'b0; chipselect = 1'b0; write_n = 1'b1;
    chk("rst out", 32'(out_port), 32'hA5);
    rd("rst data", 3'd0, 32'hA5);
    rd("rst blink", 3'd4, 32'h0);
    rd("rst period", 3'd5, 32'h0);
    rd("rst status", 3'd6, 32'h0);
    tick();
    chk("rst out +1", 32'(out_port), 32'hA5);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      reset = $urandom_range(0, 99) == 0;
      chipselect = $urandom_range(0, 1) == 1;
      write_n = $urandom_range(0, 2) == 0;
      address = 3'($urandom_range(0, 7));
      writedata = address == 3'd5 ? {8'($urandom), 16'h0, 8'($urandom_range(0, 5))} : $urandom;
      #1;
      chk($sformatf("rnd%0d rd a%0d", i, address), readdata, m_rd(address));
      chk($sformatf("rnd%0d out", i), 32'(out_port), 32'(mo));
      tick();
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
